dsp_addsub_acc: RTL
===================

// Module: dsp_addsub_acc
// PURPOSE
//  - Parametrised, pipelined multi-lane signed adder/subtractor/accumulator for the spatial-filter datapath.
//  - Successor to the fixed 48-bit two-input adder. Adds lane count, a selectable operation and
//    optional saturation, plus a valid-aligned output and overflow flag.
//  - Sits after the multiplier array. Sums partial products and accumulates kernel taps.
// PARAMETERS
//  WIDTH   48  operand/result width per lane, two's complement signed
//  LANES   4   independent parallel lanes, packed lane 0 in LSBs
//  PIPE    2   total latency in cycles, IN to OUT (>=1)
//  SAT     1   1 = saturate on signed overflow; 0 = wrap modulo 2^WIDTH
// PORTS
//  CLK        in   1            rising-edge clock
//  RST        in   1            synchronous, active-high reset
//  IN_VALID   in   1            operands and MODE are valid this cycle
//  MODE       in   2            00 A+B, 01 A-B, 10 ACC+=A, 11 ACC=A (load)
//  AIN        in   LANES*WIDTH  operand A, one WIDTH slice per lane
//  BIN        in   LANES*WIDTH  operand B, ignored in modes 10/11
//  OUT_VALID  out  1            OUT and OVF are valid this cycle
//  OUT        out  LANES*WIDTH  per-lane result
//  OVF        out  LANES        per-lane signed-overflow flag, aligned with OUT
// BEHAVIOUR
//  - Reset: on RST=1 at a clock edge, OUT, OVF, OUT_VALID, all pipeline registers and every lane
//    accumulator are cleared to 0.
//  - RST overrides IN_VALID in the same cycle. Data in flight is discarded.
//  - No backpressure. One operation may be accepted every cycle.
//  - Latency: an operation accepted at edge N appears at edge N+PIPE with OUT_VALID=1 for exactly one
//    cycle. OUT_VALID is IN_VALID delayed by PIPE cycles.
//  - While OUT_VALID=0, OUT and OVF hold their last values.
//  - Stage 1 (arithmetic), per lane:
//      - Operands are sign-extended to WIDTH+1 bits.
//      - Mode 00 computes A+B. Mode 01 computes A-B. Mode 10 computes ACC+A. Mode 11 passes A.
//      - Overflow is set when bits [WIDTH] and [WIDTH-1] of the WIDTH+1-bit result differ.
//      - Result when SAT=1: overflow clamps to +(2^(WIDTH-1))-1 or -(2^(WIDTH-1)), selected by bit [WIDTH].
//      - Result when SAT=0: the low WIDTH bits are kept.
//  - Accumulator: one WIDTH register per lane, updated in stage 1 only when IN_VALID=1 and MODE is 10 or 11.
//      - The stored value is the (saturated or wrapped) stage-1 result, so back-to-back accumulates
//        are correct at any PIPE.
//      - Modes 00/01 never modify ACC.
//  - Stages 2..PIPE are pure delay registers for result, OVF and valid.
//  - PIPE=1: the stage-1 register is the output register.
//  - MODE may change every cycle. An accumulate directly after a load uses the freshly loaded value.
//  - Boundary conditions:
//      - Most-negative minus most-positive overflows.
//      - A - (-2^(WIDTH-1)) is handled by the WIDTH+1 datapath with no special case.
//      - Lanes never interact. A carry or overflow in one lane does not affect its neighbours.
// STRUCTURE
//  - Package dsp_pkg holds:
//      - localparams MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_LOAD=2'b11;
//      - a sat_clamp function (WIDTH+1 -> WIDTH, returns the ovf bit).
//  - Sub-module dsp_addsub_lane contains one lane: stage-1 arithmetic, ACC register, saturation.
//    The top instantiates LANES copies in a generate loop.
//  - The top owns the shared valid/delay pipeline (PIPE-1 stages) and the OVF/OUT packing.
//  - Target: one DSP48 per lane. No multipliers used.
// TESTING  (WIDTH=48, LANES=4, PIPE=2 unless stated)
//  1. Reset: hold RST 2 cycles with IN_VALID=1.
//     -> OUT=0, OVF=0, OUT_VALID=0.
//     -> After release, the first accumulate (mode 10, A=5) gives OUT=5.
//  2. Add overflow, SAT=1: A=48'd140737488355327 (2^47-1), B=48'd140737488355326, mode 00.
//     -> Two cycles later OUT=48'h7FFF_FFFF_FFFF and OVF=1.
//     -> With SAT=0: OUT=48'hFFFF_FFFF_FFFD, OVF=1.
//  3. Plain add/sub:
//     -> A=2020, B=2020, mode 00 gives OUT=4040, OVF=0.
//     -> Next cycle, A=1115, B=1111, mode 01 gives OUT=4, OVF=0.
//     -> OUT_VALID is high for exactly these 2 cycles.
//  4. Accumulate: load 100 (mode 11), then back-to-back mode 10 with A=1,2,3.
//     -> OUT sequence 100,101,103,106 on consecutive cycles.
//     -> An interleaved mode-00 op leaves ACC unchanged.
//  5. Lane independence: lane0 gets an overflowing add, lanes 1-3 get 1+1.
//     -> OVF=4'b0001, lanes 1-3 OUT=2.
//     -> Negative saturation in lane 2 (-2^47 - 1) gives 48'h8000_0000_0000.
//  6. Latency sweep: PIPE=1 and PIPE=4 with the valid pattern 1,0,1,1.
//     -> OUT_VALID reproduces the pattern delayed by exactly PIPE.
//     -> RST asserted mid-stream flushes all pending valids.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the add/sub/accumulate datapath: operation codes and
// the signed saturation helper used by every lane.
package dsp_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Widest lane the helper supports; lanes sign-extend their WIDTH+1 sum up to this.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } clamp_t;

  // Reduce a (width+1)-bit signed sum to width bits: flag overflow when the two
  // top bits disagree, then clamp toward the sign of the true result or wrap.
  function automatic clamp_t sat_clamp(input logic [MAX_W:0] sum,
                                       input int             width,
                                       input logic           sat);
    clamp_t           r;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] pos_max;
    logic [MAX_W-1:0] neg_min;
    mask    = (MAX_W'(1) << width) - MAX_W'(1);
    pos_max = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    neg_min = MAX_W'(1) << (width - 1);
    r.ovf   = sum[width] ^ sum[width-1];
    r.val   = sum[MAX_W-1:0] & mask;
    if (r.ovf && sat) r.val = sum[width] ? neg_min : pos_max;
    return r;
  endfunction

endpackage

// File: rtl/dsp_addsub_lane.sv
// One lane of the datapath: stage-1 signed arithmetic, its accumulator and
// saturation/wrap. Result and overflow are registered only for valid operations.
module dsp_addsub_lane
  import dsp_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [WIDTH:0]       a_x;
  logic [WIDTH:0]       b_x;
  logic [WIDTH:0]       acc_x;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc;
  clamp_t               cl;
  logic [WIDTH-1:0]     next_val;
  logic                 unused_hi;

  always_comb begin
    a_x   = {a[WIDTH-1], a};
    b_x   = {b[WIDTH-1], b};
    acc_x = {acc[WIDTH-1], acc};
    unique case (mode)
      MODE_ADD: sum = a_x + b_x;
      MODE_SUB: sum = a_x - b_x;
      MODE_ACC: sum = acc_x + a_x;
      default:  sum = a_x;
    endcase
    cl       = sat_clamp({{(MAX_W - WIDTH){sum[WIDTH]}}, sum}, WIDTH, SAT != 0);
    next_val = cl.val[WIDTH-1:0];
  end

  assign unused_hi = ^cl.val[MAX_W-1:WIDTH];

  // ACC stores the post-clamp value so an accumulate right after a load or
  // another accumulate sees it on the very next cycle, independent of PIPE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
      ovf <= 1'b0;
    end else if (in_valid) begin
      res <= next_val;
      ovf <= cl.ovf;
      if (mode == MODE_ACC || mode == MODE_LOAD) acc <= next_val;
    end
  end

endmodule

// File: rtl/dsp_addsub_acc.sv
// Multi-lane pipelined signed add/sub/accumulate. Lanes compute stage 1; this
// level carries the shared valid and the PIPE-1 pure delay stages.
module dsp_addsub_acc
  import dsp_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int LANES = 4,
  parameter int PIPE  = 2,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] ain,
  input  logic [LANES*WIDTH-1:0] bin,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       ovf
);

  // Valid protocol: in_valid qualifies mode/ain/bin for one cycle, always
  // accepted (no ready). out_valid is in_valid delayed PIPE cycles and pulses once
  // per operation; out/ovf hold their last value while out_valid is low.
  logic                   s1_valid;
  logic [LANES*WIDTH-1:0] s1_res;
  logic [LANES-1:0]       s1_ovf;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dsp_addsub_lane #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .mode     (mode),
      .a        (ain[l*WIDTH +: WIDTH]),
      .b        (bin[l*WIDTH +: WIDTH]),
      .res      (s1_res[l*WIDTH +: WIDTH]),
      .ovf      (s1_ovf[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= in_valid;
  end

  if (PIPE == 1) begin : g_nodly
    assign out_valid = s1_valid;
    assign out       = s1_res;
    assign ovf       = s1_ovf;
  end else begin : g_dly
    logic [LANES*WIDTH-1:0] d_res [PIPE-1];
    logic [LANES-1:0]       d_ovf [PIPE-1];
    logic [PIPE-2:0]        d_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < PIPE - 1; k++) begin
          d_res[k] <= '0;
          d_ovf[k] <= '0;
        end
        d_vld <= '0;
      end else begin
        d_vld[0] <= s1_valid;
        if (s1_valid) begin
          d_res[0] <= s1_res;
          d_ovf[0] <= s1_ovf;
        end
        for (int k = 1; k < PIPE - 1; k++) begin
          d_vld[k] <= d_vld[k-1];
          if (d_vld[k-1]) begin
            d_res[k] <= d_res[k-1];
            d_ovf[k] <= d_ovf[k-1];
          end
        end
      end
    end

    assign out_valid = d_vld[PIPE-2];
    assign out       = d_res[PIPE-2];
    assign ovf       = d_ovf[PIPE-2];
  end

endmodule
